// File: rtl/mul_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: op codes, FSM states, widths.
package mul_hilo_unit_pkg;

  // Operand width the unit is built for; the product is twice this.
  localparam int WIDTH_DEFAULT = 32;

  // Request operation encoding on req_op.
  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_MFHI = 2'b01,
    OP_MFLO = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    WRITE  = 2'b11
  } state_e;

endpackage

// File: rtl/mul_hilo_unit_boothmult.sv
// Radix-2 Booth multiplier: signed M x Q in W iterations after a start pulse.
// done rises with the last iteration and stays high until the next start,
// so a consumer must ignore it until its own run has been launched.
module boothmult #(
  parameter int W = 32
) (
  input  logic [W-1:0]   M,
  input  logic [W-1:0]   Q,
  input  logic           clk,
  input  logic           start,
  output logic [2*W-1:0] out,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  // Accumulator carries one guard bit so that subtracting the most negative
  // multiplicand cannot overflow.
  logic [W:0]    acc_q;
  logic [W:0]    m_q;
  logic [W-1:0]  mq_q;
  logic          q1_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic [W:0]    sum;

  // Booth add/subtract selected by the current multiplier bit pair.
  always_comb begin
    sum = acc_q;
    case ({mq_q[0], q1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  // Load on start, then one add-and-arithmetic-shift step per cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      acc_q  <= '0;
      m_q    <= {M[W-1], M};
      mq_q   <= Q;
      q1_q   <= 1'b0;
      cnt_q  <= CW'(W);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      {acc_q, mq_q, q1_q} <= {sum[W], sum, mq_q};
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign out  = {acc_q[W-1:0], mq_q};
  assign done = done_q;

endmodule

// File: rtl/mul_hilo_unit.sv
// HI/LO multiply unit: MULT launches the Booth multiplier and writes the
// 64-bit product into HI/LO; MFHI/MFLO return HI or LO one cycle after
// acceptance. A stuck multiplier is abandoned after TIMEOUT wait cycles.
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               start_q, start_d;
  logic [2*WIDTH-1:0] mult_out;
  logic               mult_done;

  // The multiplier samples the operands latched at acceptance, so the
  // requester is free to change req_a/req_b while the multiply runs.
  boothmult #(
    .W(WIDTH)
  ) u_boothmult (
    .M     (a_q),
    .Q     (b_q),
    .clk   (clk),
    .start (start_q),
    .out   (mult_out),
    .done  (mult_done)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and datapath decisions; done is only honoured in WAIT.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          case (op_e'(req_op))
            OP_MULT: begin
              a_d     = req_a;
              b_d     = req_b;
              start_d = 1'b1;
              state_d = LAUNCH;
            end
            OP_MFHI: begin
              rd_valid_d = 1'b1;
              rd_data_d  = hi_q;
            end
            OP_MFLO: begin
              rd_valid_d = 1'b1;
              rd_data_d  = lo_q;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mult_done) begin
          state_d = WRITE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WRITE: begin
        hi_d    = mult_out[2*WIDTH-1:WIDTH];
        lo_d    = mult_out[WIDTH-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Bench for mul_hilo_unit: directed cases plus randomized traffic, all
// checked every cycle against a transaction-level model of the unit.
module tb_mul_hilo_unit;

  localparam int TMO     = 40;
  localparam int MUL_LAT = 32 + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;
  int txn = 0;
  bit force_done = 1'b0;

  always #5 clk = ~clk;

  mul_hilo_unit #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a MULT keeps the unit busy for MUL_LAT edges
  // and then commits the signed 64-bit product; with done held low it is
  // abandoned after one launch cycle plus TMO wait cycles.
  logic        m_busy = 1'b0;
  int          m_age = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_rd = '0;
  logic        m_rv = 1'b0;
  logic        m_err = 1'b0;
  longint      m_prod = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_rd   <= '0;
      m_rv   <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      m_rv <= 1'b0;
      if (m_busy) begin
        m_age <= m_age + 1;
        if (!force_done && (m_age + 1 == MUL_LAT)) begin
          m_busy <= 1'b0;
          m_hi   <= m_prod[63:32];
          m_lo   <= m_prod[31:0];
        end else if (force_done && (m_age + 1 == TMO + 1)) begin
          m_busy <= 1'b0;
          m_err  <= 1'b1;
        end
      end else if (req_valid) begin
        case (req_op)
          2'd0: begin
            m_busy <= 1'b1;
            m_age  <= 0;
            m_prod <= longint'($signed(req_a)) * longint'($signed(req_b));
          end
          2'd1: begin m_rv <= 1'b1; m_rd <= m_hi; end
          2'd2: begin m_rv <= 1'b1; m_rd <= m_lo; end
          default: m_err <= 1'b1;
        endcase
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    check("req_ready", req_ready, !m_busy);
    check("busy", busy, m_busy);
    check("rd_valid", rd_valid, m_rv);
    check("rd_data", rd_data, m_rd);
    check("err", err, m_err);
  end

  // Present a request and hold it until accepted. Entered and left at
  // posedge+2; stall counts the polls that found req_ready low.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stall);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    stall     = 0;
    while (!req_ready) begin
      @(posedge clk); #2;
      stall++;
      if (stall > 200) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout actual=not_ready required=ready");
        break;
      end
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    txn++;
    $display("txn %0d op=%0d a=0x%08h b=0x%08h stall=%0d", txn, op, a, b, stall);
  endtask

  task automatic read_chk(input logic [1:0] op, input string name, input logic [31:0] exp);
    int st;
    issue(op, '0, '0, st);
    check({name, "_valid"}, rd_valid, 1'b1);
    check(name, rd_data, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int k;
    logic [1:0] op;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    // Reset values of the outputs.
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    check("ready_after_reset", req_ready, 1'b1);

    // 2 * 3 = 6.
    issue(2'd0, 32'd2, 32'd3, st);
    wait_idle();
    read_chk(2'd2, "mflo_2x3", 32'd6);
    read_chk(2'd1, "mfhi_2x3", 32'd0);
    check("err_2x3", err, 1'b0);

    // -2 * 3.
    issue(2'd0, 32'hFFFF_FFFE, 32'd3, st);
    wait_idle();
    read_chk(2'd1, "mfhi_neg", 32'hFFFF_FFFF);
    read_chk(2'd2, "mflo_neg", 32'hFFFF_FFFA);

    // Most negative squared.
    issue(2'd0, 32'h8000_0000, 32'h8000_0000, st);
    wait_idle();
    read_chk(2'd1, "mfhi_min", 32'h4000_0000);
    read_chk(2'd2, "mflo_min", 32'h0000_0000);

    // MFLO right behind a MULT stalls through LAUNCH, WAIT and WRITE.
    issue(2'd0, 32'd7, 32'd5, st);
    issue(2'd2, '0, '0, st);
    check("stall_cycles", st, MUL_LAT);
    check("mflo_7x5", rd_data, 32'd35);

    // Reset during WAIT abandons the multiply; a late done is ignored.
    issue(2'd0, 32'd9, 32'd9, st);
    cycles(10);
    do_reset();
    read_chk(2'd2, "mflo_after_rst", 32'd0);
    check("busy_after_rst", busy, 1'b0);
    check("err_after_rst", err, 1'b0);
    cycles(40);
    read_chk(2'd1, "mfhi_late_done", 32'd0);

    // Reserved op: sets err, no read response, HI/LO untouched.
    issue(2'd0, 32'hFFFF_FFFE, 32'd3, st);
    wait_idle();
    issue(2'd3, '0, '0, st);
    check("rsvd_no_rd_valid", rd_valid, 1'b0);
    check("rsvd_err", err, 1'b1);
    read_chk(2'd2, "mflo_after_rsvd", 32'hFFFF_FFFA);

    // Multiplier done held low: abort after launch plus TMO wait cycles.
    do_reset();
    issue(2'd0, 32'hFFFF_FFFE, 32'd3, st);
    wait_idle();
    force_done = 1'b1;
    force dut.mult_done = 1'b0;
    issue(2'd0, 32'd100, 32'd100, st);
    k = 0;
    while (!err && k < 100) begin
      @(posedge clk); #2;
      k++;
    end
    check("timeout_cycles", k, TMO + 1);
    check("timeout_busy", busy, 1'b0);
    release dut.mult_done;
    force_done = 1'b0;
    read_chk(2'd2, "mflo_after_tmo", 32'hFFFF_FFFA);
    read_chk(2'd1, "mfhi_after_tmo", 32'hFFFF_FFFF);

    // Randomized traffic, back-to-back requests included.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 19);
      if (k < 10) op = 2'd0;
      else if (k < 14) op = 2'd1;
      else if (k < 18) op = 2'd2;
      else if (k == 18 && i > 40) op = 2'd3;
      else op = 2'd2;
      issue(op, rand_operand(), rand_operand(), st);
      cycles($urandom_range(0, 2));
    end
    wait_idle();
    read_chk(2'd1, "final_hi_valid_path", m_hi);
    read_chk(2'd2, "final_lo_valid_path", m_lo);
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
